// File: rtl/regf_write_sequencer.sv
// Write-side front end for the dual-write-port register file: buffers up to two
// writeback requests per cycle in an in-order queue and drains up to two per cycle.
module regf_write_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 6,
    parameter int DW    = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_flush,
    input  logic                         i_req_valid_a,
    input  logic [AW-1:0]                i_req_addr_a,
    input  logic [DW-1:0]                i_req_data_a,
    input  logic                         i_req_valid_b,
    input  logic [AW-1:0]                i_req_addr_b,
    input  logic [DW-1:0]                i_req_data_b,
    output logic                         o_req_ready,
    output logic [AW-1:0]                o_wr_addr_a,
    output logic [DW-1:0]                o_wr_data_a,
    output logic [AW-1:0]                o_wr_addr_b,
    output logic [DW-1:0]                o_wr_data_b,
    output logic                         o_wen,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, wr_ptr_b, rd_ptr_b;
    logic [CW-1:0] count, count_next;
    logic          push_a, push_b, pop_two, pop_one;
    logic [1:0]    n_push, n_pop;

    assign o_req_ready = (count <= CW'(DEPTH - 2));
    assign push_a      = i_req_valid_a && o_req_ready && !i_flush;
    assign push_b      = i_req_valid_b && o_req_ready && !i_flush;
    // B lands right after A when both are pushed, otherwise in A's slot
    assign wr_ptr_b    = wr_ptr + PW'(push_a);
    assign rd_ptr_b    = rd_ptr + PW'(1);

    assign pop_two     = (count >= CW'(2));
    assign pop_one     = (count == CW'(1));
    assign n_push      = 2'(push_a) + 2'(push_b);
    assign n_pop       = pop_two ? 2'd2 : (pop_one ? 2'd1 : 2'd0);
    assign count_next  = count + CW'(n_push) - CW'(n_pop);

    assign o_count     = count;
    assign o_empty     = (count == '0) && !o_wen;

    // Storage needs no reset: occupancy alone decides which slots are live
    always_ff @(posedge i_clk) begin
        if (push_a) begin
            q_addr[wr_ptr] <= i_req_addr_a;
            q_data[wr_ptr] <= i_req_data_a;
        end
        if (push_b) begin
            q_addr[wr_ptr_b] <= i_req_addr_b;
            q_data[wr_ptr_b] <= i_req_data_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (i_flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count  <= count_next;
            rd_ptr <= rd_ptr + PW'(n_pop);
            wr_ptr <= wr_ptr + PW'(n_push);
        end
    end

    // Older entry always on port A, younger on B; the RAM favours B on collisions
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wen       <= 1'b0;
            o_wr_addr_a <= '0;
            o_wr_data_a <= '0;
            o_wr_addr_b <= '0;
            o_wr_data_b <= '0;
        end else if (i_flush) begin
            o_wen <= 1'b0;
        end else if (pop_two) begin
            o_wen       <= 1'b1;
            o_wr_addr_a <= q_addr[rd_ptr];
            o_wr_data_a <= q_data[rd_ptr];
            o_wr_addr_b <= q_addr[rd_ptr_b];
            o_wr_data_b <= q_data[rd_ptr_b];
        end else if (pop_one) begin
            o_wen       <= 1'b1;
            o_wr_addr_a <= q_addr[rd_ptr];
            o_wr_data_a <= q_data[rd_ptr];
            o_wr_addr_b <= q_addr[rd_ptr];
            o_wr_data_b <= q_data[rd_ptr];
        end else begin
            o_wen <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regf_write_sequencer.sv
// Scoreboard bench: a reference queue model pushes per-cycle expectations,
// a negedge monitor pops and compares them against the RAM-side outputs.
module tb_regf_write_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_flush;
    logic          i_req_valid_a, i_req_valid_b;
    logic [AW-1:0] i_req_addr_a, i_req_addr_b;
    logic [DW-1:0] i_req_data_a, i_req_data_b;
    logic          o_req_ready, o_wen, o_empty;
    logic [AW-1:0] o_wr_addr_a, o_wr_addr_b;
    logic [DW-1:0] o_wr_data_a, o_wr_data_b;
    logic [CW-1:0] o_count;

    regf_write_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_flush(i_flush),
        .i_req_valid_a(i_req_valid_a), .i_req_addr_a(i_req_addr_a), .i_req_data_a(i_req_data_a),
        .i_req_valid_b(i_req_valid_b), .i_req_addr_b(i_req_addr_b), .i_req_data_b(i_req_data_b),
        .o_req_ready(o_req_ready),
        .o_wr_addr_a(o_wr_addr_a), .o_wr_data_a(o_wr_data_a),
        .o_wr_addr_b(o_wr_addr_b), .o_wr_data_b(o_wr_data_b),
        .o_wen(o_wen), .o_count(o_count), .o_empty(o_empty)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic          wen;
        logic [AW-1:0] aa, ab;
        logic [DW-1:0] da, db;
        int            cnt;
        logic          rdy;
        logic          emp;
    } exp_t;

    ent_t          mq[$];
    exp_t          exp_q[$];
    logic [AW-1:0] last_aa, last_ab;
    logic [DW-1:0] last_da, last_db;
    logic [DW-1:0] ram [1<<AW];
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pop decision from pre-edge occupancy, then push A before B
    always @(posedge i_clk) begin
        if (i_reset_n) begin
            exp_t e;
            ent_t na, nb;
            int   n;
            logic rdy;
            n     = mq.size();
            rdy   = (n <= DEPTH - 2);
            e.wen = 1'b0;
            e.aa  = last_aa; e.da = last_da; e.ab = last_ab; e.db = last_db;
            if (i_flush) begin
                mq.delete();
            end else begin
                if (n >= 2) begin
                    na = mq.pop_front(); nb = mq.pop_front();
                    e.wen = 1'b1; e.aa = na.a; e.da = na.d; e.ab = nb.a; e.db = nb.d;
                end else if (n == 1) begin
                    na = mq.pop_front();
                    e.wen = 1'b1; e.aa = na.a; e.da = na.d; e.ab = na.a; e.db = na.d;
                end
                if (rdy && i_req_valid_a) mq.push_back('{i_req_addr_a, i_req_data_a});
                if (rdy && i_req_valid_b) mq.push_back('{i_req_addr_b, i_req_data_b});
            end
            e.cnt = mq.size();
            e.rdy = (mq.size() <= DEPTH - 2);
            e.emp = (mq.size() == 0) && !e.wen;
            last_aa = e.aa; last_da = e.da; last_ab = e.ab; last_db = e.db;
            exp_q.push_back(e);
        end
    end

    always @(negedge i_clk) begin
        if (i_reset_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_wen",    64'(o_wen),       64'(e.wen));
            chk("sb_addr_a", 64'(o_wr_addr_a), 64'(e.aa));
            chk("sb_data_a", 64'(o_wr_data_a), 64'(e.da));
            chk("sb_addr_b", 64'(o_wr_addr_b), 64'(e.ab));
            chk("sb_data_b", 64'(o_wr_data_b), 64'(e.db));
            chk("sb_count",  64'(o_count),     64'(e.cnt));
            chk("sb_ready",  64'(o_req_ready), 64'(e.rdy));
            chk("sb_empty",  64'(o_empty),     64'(e.emp));
            if (o_wen) begin
                ram[o_wr_addr_a] = o_wr_data_a;
                ram[o_wr_addr_b] = o_wr_data_b;
            end
        end
    end

    task automatic clear_inputs();
        i_flush = 0;
        i_req_valid_a = 0; i_req_addr_a = '0; i_req_data_a = '0;
        i_req_valid_b = 0; i_req_addr_b = '0; i_req_data_b = '0;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_q.delete();
        last_aa = '0; last_ab = '0; last_da = '0; last_db = '0;
    endtask

    // Drive at negedge and hold until ready is seen (bounded), then take the edge
    task automatic send(input logic va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                        input logic vb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                        input logic fl);
        logic ok;
        @(negedge i_clk);
        i_req_valid_a = va; i_req_addr_a = aa; i_req_data_a = da;
        i_req_valid_b = vb; i_req_addr_b = ab; i_req_data_b = db;
        i_flush = fl;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (o_req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge i_clk);
        end
        if (!ok) chk("ready_timeout", 64'(ok), 64'(1));
        @(posedge i_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge i_clk);
            clear_inputs();
            @(posedge i_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = '0;
        clear_inputs();
        model_reset();
        i_reset_n = 1'b0;
        #23;
        chk("rst_wen",    64'(o_wen),       64'(0));
        chk("rst_addr_a", 64'(o_wr_addr_a), 64'(0));
        chk("rst_data_b", 64'(o_wr_data_b), 64'(0));
        chk("rst_count",  64'(o_count),     64'(0));
        chk("rst_empty",  64'(o_empty),     64'(1));
        chk("rst_ready",  64'(o_req_ready), 64'(1));
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Single A request: both ports carry it one edge after acceptance
        send(1, 6'd5, 32'hDEADBEEF, 0, '0, '0, 0);
        idle(1); #1;
        chk("single_wen",    64'(o_wen),       64'(1));
        chk("single_addr_a", 64'(o_wr_addr_a), 64'(5));
        chk("single_data_a", 64'(o_wr_data_a), 64'(32'hDEADBEEF));
        chk("single_addr_b", 64'(o_wr_addr_b), 64'(5));
        chk("single_data_b", 64'(o_wr_data_b), 64'(32'hDEADBEEF));
        idle(1); #1;
        chk("single_wen_off", 64'(o_wen),   64'(0));
        chk("single_empty",   64'(o_empty), 64'(1));

        // Sustained dual stream
        for (int i = 0; i < 20; i++) begin
            send(1, 6'd3, 32'h11, 1, 6'd4, 32'h22, 0); #1;
            chk("dual_ready", 64'(o_req_ready), 64'(1));
            chk("dual_cnt_le2", 64'(o_count <= 2), 64'(1));
            if (i > 0) begin
                chk("dual_wen", 64'(o_wen), 64'(1));
                chk("dual_a", {26'd0, o_wr_addr_a, o_wr_data_a}, {26'd0, 6'd3, 32'h11});
                chk("dual_b", {26'd0, o_wr_addr_b, o_wr_data_b}, {26'd0, 6'd4, 32'h22});
            end
        end
        idle(3);

        // Same-address pair: younger on B, B-priority RAM keeps it
        send(1, 6'd7, 32'hAA, 1, 6'd7, 32'hBB, 0);
        idle(1); #1;
        chk("same_a", {26'd0, o_wr_addr_a, o_wr_data_a}, {26'd0, 6'd7, 32'hAA});
        chk("same_b", {26'd0, o_wr_addr_b, o_wr_data_b}, {26'd0, 6'd7, 32'hBB});
        idle(2);
        chk("same_ram7", 64'(ram[7]), 64'(32'hBB));

        // Burst of three pairs and a single; order and completeness via scoreboard
        send(1, 6'd10, 32'h100, 1, 6'd11, 32'h101, 0); #1;
        chk("burst_cnt1", 64'(o_count), 64'(2));
        send(1, 6'd12, 32'h102, 1, 6'd13, 32'h103, 0);
        send(1, 6'd14, 32'h104, 1, 6'd15, 32'h105, 0);
        send(1, 6'd16, 32'h106, 0, '0, '0, 0); #1;
        chk("burst_a", {26'd0, o_wr_addr_a, o_wr_data_a}, {26'd0, 6'd14, 32'h104});
        chk("burst_cnt4", 64'(o_count), 64'(1));
        idle(1); #1;
        chk("burst_last", {26'd0, o_wr_addr_b, o_wr_data_b}, {26'd0, 6'd16, 32'h106});
        idle(3);

        // Flush with a live queue and a valid pair on the same edge
        send(1, 6'd20, 32'h200, 1, 6'd21, 32'h201, 0);
        send(1, 6'd22, 32'h202, 1, 6'd23, 32'h203, 1); #1;
        chk("flush_count", 64'(o_count), 64'(0));
        chk("flush_wen",   64'(o_wen),   64'(0));
        chk("flush_empty", 64'(o_empty), 64'(1));
        idle(2); #1;
        chk("flush_dropped", 64'(o_wen), 64'(0));
        send(1, 6'd30, 32'h300, 0, '0, '0, 0);
        idle(1); #1;
        chk("postflush_b", {26'd0, o_wr_addr_b, o_wr_data_b}, {26'd0, 6'd30, 32'h300});
        idle(2);

        // B alone
        send(0, '0, '0, 1, 6'd40, 32'h400, 0);
        idle(1); #1;
        chk("bonly_a", {26'd0, o_wr_addr_a, o_wr_data_a}, {26'd0, 6'd40, 32'h400});
        idle(2);

        // Asynchronous reset in the middle of a drain
        send(1, 6'd50, 32'h500, 1, 6'd51, 32'h501, 0);
        send(1, 6'd52, 32'h502, 1, 6'd53, 32'h503, 0); #1;
        chk("pre_rst_wen", 64'(o_wen), 64'(1));
        #1;
        i_reset_n = 1'b0;
        clear_inputs();
        model_reset();
        #1;
        chk("async_rst_wen",   64'(o_wen),       64'(0));
        chk("async_rst_count", 64'(o_count),     64'(0));
        chk("async_rst_empty", 64'(o_empty),     64'(1));
        chk("async_rst_addr",  64'(o_wr_addr_a), 64'(0));
        @(negedge i_clk);
        i_reset_n = 1'b1;
        idle(4); #1;
        chk("post_rst_empty", 64'(o_empty), 64'(1));
        @(negedge i_clk); #1;
        chk("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
